// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared definitions for the HD44780 LCD drivers (init sequencer and
//   byte writer):
//   - HD44780 command opcodes
//   - the byte writer state enumeration
//   - the slow-command predicate. Clear display and return home need
//     about 1.52 ms, while every other instruction needs about 37 us.
package lcd_pkg;

  // HD44780 instruction opcodes.
  localparam logic [7:0] CLEARDISPLAY   = 8'h01;
  localparam logic [7:0] RETURNHOME     = 8'h02;
  localparam logic [7:0] ENTRYMODESET   = 8'h04;
  localparam logic [7:0] DISPLAYCONTROL = 8'h08;
  localparam logic [7:0] FUNCTIONSET    = 8'h20;
  localparam logic [7:0] SETDDRAMADDR   = 8'h80;

  // Byte writer phases. Each phase lasts one 1 ms clock.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI_EN = 3'd1,
    ST_HI_LO = 3'd2,
    ST_LO_EN = 3'd3,
    ST_LO_LO = 3'd4,
    ST_WAIT  = 3'd5
  } writer_state_t;

  // Returns true for clear display (0x01) and return home (0x02/0x03).
  // These are the only commands with a long execution time. A command
  // byte of 0x00 is grouped with them so that it is handled safely.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] value);
    return (!rs) && (value[7:2] == 6'd0);
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer
//   Byte-level HD44780 transmitter for the 4-bit data phase that follows
//   power-on init. Each accepted byte is sent as two enable-strobed
//   nibbles, high nibble first. The block then idles for the command
//   execution time before it accepts the next byte.
//
// Parameters
//   FAST_WAIT  idle cycles after a normal byte (1 ms clock already > 37 us)
//   SLOW_WAIT  idle cycles after clear/home
//
// Ports
//   clk        1 kHz system clock
//   reset      asynchronous, active-high reset
//   init_done  high once the LCD init sequence has completed
//   in_valid   upstream byte available
//   in_rs      0 = command, 1 = character data
//   in_data    byte to send
//   in_ready   block accepts a byte this cycle (combinational)
//   busy       transfer or post-byte wait in progress (registered)
//   en         LCD enable strobe (registered)
//   rs         LCD register select (registered)
//   data       LCD DB7..DB4 (registered)
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int FAST_WAIT = 0,
  parameter int SLOW_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       en,
  output logic       rs,
  output logic [3:0] data
);

  localparam int MAX_WAIT = (FAST_WAIT > SLOW_WAIT) ? FAST_WAIT : SLOW_WAIT;
  localparam int CNT_W    = ($clog2(MAX_WAIT + 1) < 2) ? 2 : $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'(FAST_WAIT);
  localparam logic [CNT_W-1:0] SLOW_LOAD = CNT_W'(SLOW_WAIT);

  writer_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       byte_reg, byte_next;
  logic             en_reg, en_next;
  logic             rs_reg, rs_next;
  logic [3:0]       data_reg, data_next;
  logic             busy_reg, busy_next;

  logic             transfer;
  logic [CNT_W-1:0] wait_load;

  assign in_ready = (state_reg == ST_IDLE) && init_done;
  assign transfer = in_valid && in_ready;

  // Wait length of the byte currently in flight. rs_reg holds the
  // register select latched at acceptance.
  assign wait_load = is_slow_cmd(rs_reg, byte_reg) ? SLOW_LOAD : FAST_LOAD;

  assign en   = en_reg;
  assign rs   = rs_reg;
  assign data = data_reg;
  assign busy = busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      byte_reg  <= '0;
      en_reg    <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      byte_reg  <= byte_next;
      en_reg    <= en_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
    end
  end

  // Pin values are computed for the state being entered, so that en, rs
  // and data are registered alongside it. The low-nibble en-low phase
  // (LO_LO) overlaps the cycle that leaves LO_EN. At that edge the wait
  // counter is loaded and the machine moves straight to WAIT, or to IDLE
  // when the wait is zero. This keeps the back-to-back rate at 4+W cycles
  // per byte. A LO_LO value in the state register is handled in the same
  // way.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    byte_next  = byte_reg;
    en_next    = 1'b0;
    rs_next    = rs_reg;
    data_next  = data_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_HI_EN;
          byte_next  = in_data;
          rs_next    = in_rs;
          data_next  = in_data[7:4];
          en_next    = 1'b1;
        end
      end
      ST_HI_EN: begin
        state_next = ST_HI_LO;
      end
      ST_HI_LO: begin
        state_next = ST_LO_EN;
        data_next  = byte_reg[3:0];
        en_next    = 1'b1;
      end
      ST_LO_EN, ST_LO_LO: begin
        cnt_next   = wait_load;
        state_next = (wait_load == '0) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        // The counter is loaded with N. The last WAIT cycle is the one
        // that sees the counter at 1, so WAIT lasts exactly N cycles.
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Byte-level HD44780 transmitter for the data phase, after the LCD power-on init sequence has finished. Accepts 8-bit command or character bytes from an upstream message source over a valid/ready handshake. Emits each byte as two 4-bit nibbles (high first) on the LCD `en`/`rs`/`data` pins, then enforces the command execution delay. Runs on the same 1 kHz (1 ms period) clock as the init driver; its pin outputs are muxed onto the LCD once `init_done` is high.

## Interface
- `FAST_WAIT`, default 0: idle cycles inserted after a normal byte; 1 ms already exceeds 37 µs.
- `SLOW_WAIT`, default 2: idle cycles inserted after a slow command (clear/home; 1.52 ms).
- `clk`  in  1  system clock, 1 kHz.
- `reset`  in  1  asynchronous, active-high reset.
- `init_done`  in  1  level; high once the init sequence has completed.
- `in_valid`  in  1  upstream byte available.
- `in_rs`  in  1  0 = command, 1 = character data.
- `in_data`  in  8  byte to send.
- `in_ready`  out  1  block can accept a byte this cycle.
- `busy`  out  1  transfer or post-byte wait in progress.
- `en`  out  1  LCD enable strobe.
- `rs`  out  1  LCD register select.
- `data`  out  4  LCD DB7..DB4.

## Operation
- States: IDLE, HI_EN, HI_LO, LO_EN, LO_LO, WAIT.
- `in_ready` = (state == IDLE) && `init_done`. It is combinational from state and the input.
- Transfer occurs on a clock edge where `in_valid && in_ready`. At that edge the block latches `in_rs` and `in_data`.
- IDLE -> HI_EN on transfer:
  - `en`=1, `rs`=latched rs, `data`=byte[7:4].
- HI_EN -> HI_LO: `en`=0; `rs`/`data` held.
- HI_LO -> LO_EN: `en`=1, `data`=byte[3:0].
- LO_EN -> LO_LO: `en`=0; `rs`/`data` held.
- LO_LO loads the wait counter, then:
  - Counter = `SLOW_WAIT` if rs=0 and byte[7:2]==0 (0x00–0x03: clear display, return home).
  - Otherwise counter = `FAST_WAIT`.
  - Counter==0 -> IDLE directly; else -> WAIT.
- WAIT: decrement each cycle; -> IDLE when counter reaches 1 (exactly N cycles spent in WAIT).
- `busy` = state != IDLE, registered alongside state.
- `rs`/`data` keep their last driven value in IDLE; only `en` returns low.
- `init_done` falling mid-transfer: the current byte completes, including its wait. No new transfer is accepted until `init_done` is high again. A nibble pair is never truncated.
- `in_valid` or `in_data` changing while not ready: ignored; no effect.
- Reset asserted at any time aborts immediately:
  - state IDLE, `en`=0, `rs`=0, `data`=0, `busy`=0, counter 0.
  - `in_ready` follows `init_done` after release.

## Timing
- Transfer accepted at edge k. Registered outputs:
  - after k: `en`=1, hi nibble.
  - after k+1: `en`=0.
  - after k+2: `en`=1, lo nibble.
  - after k+3: `en`=0.
  - back in IDLE after k+3+W (W = applied wait). `in_ready` is high in that cycle if `init_done`.
- Each `en` pulse is exactly one clock (1 ms) high. Data is stable for the whole pulse and one clock after.
- Back-to-back throughput: one byte per 4+W cycles. Defaults: 4 cycles per normal byte, 6 per clear/home.
- `busy` is high from the cycle after k through the last WAIT cycle.
- Reset release takes effect at the next clock edge; no transfer can occur on the reset-release edge.

## Structure
- Shared package `lcd_pkg` holds:
  - HD44780 command constants: CLEARDISPLAY 0x01, RETURNHOME 0x02, ENTRYMODESET 0x04, DISPLAYCONTROL 0x08, FUNCTIONSET 0x20, SETDDRAMADDR 0x80.
  - The writer state enum.
  - The slow-command predicate as a function, so the init driver and the writer agree.
- No sub-module; the wait counter (width from max(`FAST_WAIT`, `SLOW_WAIT`), min 2 bits) is inline.

## Test plan
- Reset with `init_done`=0 and `in_valid`=1 -> `in_ready`=0, `en`=0, `rs`=0, `data`=0 indefinitely. Raise `init_done` -> `in_ready`=1 the same cycle.
- Send rs=1, 0x48 ('H') -> `en` pattern 1,0,1,0 with `data` 4 then 8, `rs`=1 throughout. `in_ready` high again 4 cycles after acceptance.
- Send rs=0, 0x01 -> same nibble pattern (0, 1), then 2 WAIT cycles. Next acceptance no earlier than 6 cycles after the first.
- Stream 'H','i' with `in_valid` held high -> bytes accepted exactly 4 cycles apart. Nibble sequence 4,8,6,9; no gaps or duplicates.
- Drop `init_done` one cycle after accepting 0x41 -> both nibbles (4,1) still emitted. No further acceptance until `init_done` returns.
- Assert `reset` asynchronously while in LO_EN -> `en`, `rs`, `data`, `busy` go to 0 before the next clock edge. After release, a fresh 0x30 transfers cleanly (3, 0).
